fifo_ptr_ctrl: RTL and testbench
================================

# fifo_ptr_ctrl

Sequential back end of the 8-entry FIFO controller, sitting directly downstream of the next-state logic. Each clock it registers the next-state code into the state register. It updates the head and tail pointers and the data count, and drives the memory strobes and the handshake/status outputs. `state` and `data_count` feed back to the next-state logic; `we`, `re`, `wr_addr` and `rd_addr` go to the register-file stage.

## Interface
- `ADDR_W`, default 3: pointer width. Depth is 2^ADDR_W. `data_count` is ADDR_W+1 bits wide.
- `clk`, input, 1 bit: single clock. All registers update on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `next_state`, input, 3 bits: state code from the next-state logic.
- `state`, output, 3 bits: registered current state.
- `data_count`, output, ADDR_W+1 bits: number of occupied entries, 0..2^ADDR_W.
- `head`, output, ADDR_W bits: read pointer.
- `tail`, output, ADDR_W bits: write pointer.
- `we`, output, 1 bit: memory write strobe, registered.
- `wr_addr`, output, ADDR_W bits: address qualified by `we`.
- `re`, output, 1 bit: memory read strobe, registered.
- `rd_addr`, output, ADDR_W bits: address qualified by `re`.
- `wr_ack`, `wr_err`, `rd_ack`, `rd_err`, outputs, 1 bit each: handshake status, registered.
- `full`, `empty`, outputs, 1 bit each: combinational decode of `data_count`.
- `err_cnt`, output, 8 bits: error event count. See Configuration.

## Operation
State codes: INIT=000, WRITE=001, READ=010, NO_OP=011, WR_ERR=101, RD_ERR=110.

At every edge, `state` <= `next_state`, with one exception: unused codes (100, 111, X) load NO_OP, and no other update happens that cycle.

Push and pop rules:
- **Push:** next_state==WRITE and data_count < 2^ADDR_W.
  - `tail` <= tail+1, wrapping modulo 2^ADDR_W.
  - `data_count` +1.
  - `we` <= 1, `wr_addr` <= old `tail`.
  - `wr_ack` <= 1.
- **Pop:** next_state==READ and data_count > 0.
  - `head` <= head+1, wrapping.
  - `data_count` −1.
  - `re` <= 1, `rd_addr` <= old `head`.
  - `rd_ack` <= 1.
- **Guarded write:** next_state==WRITE while full. State still loads WRITE, but nothing moves. `we` = 0 and `wr_ack` = 0, and `wr_err` <= 1.
- **Guarded read:** next_state==READ while empty. State still loads READ, but nothing moves. `re` = 0 and `rd_ack` = 0, and `rd_err` <= 1.
- **Explicit error states:** next_state==WR_ERR sets `wr_err` <= 1; next_state==RD_ERR sets `rd_err` <= 1. Pointers and count are unchanged.
- **INIT and NO_OP:** pointers and count are held.
- **Strobes:** all strobes and ack/err bits default to 0 every cycle; each is a one-cycle pulse per qualifying edge.
- **Push and pop never coincide**, because the state is one-hot per cycle.
- **Flags:** `full` = (data_count == 2^ADDR_W); `empty` = (data_count == 0).

## Timing
- Reset values:
  - `state` = INIT.
  - `head`, `tail`, `data_count`, `wr_addr`, `rd_addr` = 0.
  - All strobes and ack/err bits = 0.
  - `err_cnt` = 0.
  - `empty` = 1, `full` = 0.
- Latency from `next_state` to the registered outputs is one clock.
- The memory samples `we`/`wr_addr` at the following edge. Data for a read is valid one edge after `re`.
- Reset asserted mid-burst clears all state immediately and asynchronously. The first edge after release loads `next_state` normally.
- Wrap-around: `tail` goes 7 → 0 on the 8th push. With 8 pushes, count = 8 and `head` == `tail` at full; `full` distinguishes this from empty.

## Configuration
- **`FIFO_ERR_CNT_EN` defined:** `err_cnt` increments on every edge that sets `wr_err` or `rd_err`. It saturates at 255 and clears only on reset.
- **Not defined:** `err_cnt` is tied to 0 and no counter flops are generated. The port list is identical in both builds.

## Structure
- Shared package `fifo_pkg` holds:
  - the state encodings above, shared with the next-state logic;
  - the `ADDR_W` default;
  - the derived `DEPTH`.
- One sub-module, `fifo_flag_dec`: combinational `data_count` → `full`/`empty` decode, instanced once and reusable by the status stage.

## Test plan
1. **Reset:** assert `reset` mid-cycle with count=3 → all outputs go to their reset values immediately, with `empty`=1.
2. **Fill and overflow:** 8 cycles of next_state=WRITE from empty.
   - `wr_addr` runs 0..7, `tail` ends at 0, `data_count` = 8, `full` = 1.
   - A 9th WRITE gives `we`=0, `wr_err`=1, count stays 8.
3. **Drain and underflow:** from full, 8 cycles of READ.
   - `rd_addr` runs 0..7, count = 0, `empty` = 1.
   - A 9th READ gives `re`=0, `rd_err`=1.
4. **Wrap with interleave:** pattern of 5 WRITE, 3 READ, 6 WRITE.
   - `tail` = 3, `head` = 3, count = 8.
   - Then 1 READ gives `rd_addr`=3, count=7.
5. **Error counter:** with `FIFO_ERR_CNT_EN` defined, 300 consecutive next_state=RD_ERR cycles → `err_cnt` = 255. Without the macro, `err_cnt` = 0 throughout.
6. **Illegal code:** next_state=3'b111 at count=4 → `state`=NO_OP, with count, pointers and strobes unchanged.

Source files
------------

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the 8-entry FIFO controller: state encodings (also
// used by the next-state logic), the default pointer width and derived depth.
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDR_W = 3;
    localparam int DEPTH       = 2 ** FIFO_ADDR_W;

    typedef enum logic [2:0] {
        ST_INIT   = 3'b000,
        ST_WRITE  = 3'b001,
        ST_READ   = 3'b010,
        ST_NO_OP  = 3'b011,
        ST_WR_ERR = 3'b101,
        ST_RD_ERR = 3'b110
    } state_e;

endpackage : fifo_pkg

// File: rtl/fifo_flag_dec.sv
// ----------------------------------------------------------------------------
// fifo_flag_dec
// Combinational occupancy decode: data_count -> full / empty.
// Ports:
//   data_count : in,  ADDR_W+1 bits, occupied entries (0..2^ADDR_W)
//   full       : out, data_count == 2^ADDR_W
//   empty      : out, data_count == 0
// ----------------------------------------------------------------------------
module fifo_flag_dec
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic [ADDR_W:0] data_count,
    output logic            full,
    output logic            empty
);

    // 2^ADDR_W is just the MSB of the count set with all lower bits clear.
    assign full  = (data_count == {1'b1, {ADDR_W{1'b0}}});
    assign empty = (data_count == '0);

endmodule : fifo_flag_dec

// File: rtl/fifo_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_ptr_ctrl
// Sequential back end of the FIFO controller. Registers the next-state code,
// moves head/tail pointers and the occupancy count, and drives registered
// memory strobes plus handshake status.
// Optional feature macro: FIFO_ERR_CNT_EN -- when defined, err_cnt counts
// error events (saturating at 255); otherwise err_cnt is tied to 0.
// Ports:
//   clk, reset        : clock, async active-high reset
//   next_state [2:0]  : state code from the next-state logic
//   state      [2:0]  : registered current state
//   data_count        : occupied entries, ADDR_W+1 bits
//   head, tail        : read / write pointers
//   we, wr_addr       : registered memory write strobe and address
//   re, rd_addr       : registered memory read strobe and address
//   wr_ack, wr_err    : write handshake status pulses
//   rd_ack, rd_err    : read handshake status pulses
//   full, empty       : combinational decode of data_count
//   err_cnt    [7:0]  : error event count
// ----------------------------------------------------------------------------
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        next_state,
    output logic [2:0]        state,
    output logic [ADDR_W:0]   data_count,
    output logic [ADDR_W-1:0] head,
    output logic [ADDR_W-1:0] tail,
    output logic              we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              re,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err,
    output logic              full,
    output logic              empty,
    output logic [7:0]        err_cnt
);

    fifo_flag_dec #(.ADDR_W(ADDR_W)) u_flag_dec (
        .data_count (data_count),
        .full       (full),
        .empty      (empty)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            data_count <= '0;
            head       <= '0;
            tail       <= '0;
            we         <= 1'b0;
            wr_addr    <= '0;
            re         <= 1'b0;
            rd_addr    <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            // NOTE: strobes default low here, so each one is a single-cycle
            // pulse unless a qualifying branch below raises it.
            we     <= 1'b0;
            re     <= 1'b0;
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            rd_ack <= 1'b0;
            rd_err <= 1'b0;

            case (next_state)
                ST_WRITE: begin
                    state <= ST_WRITE;
                    if (!full) begin
                        tail       <= tail + 1'b1;
                        data_count <= data_count + 1'b1;
                        we         <= 1'b1;
                        wr_addr    <= tail;
                        wr_ack     <= 1'b1;
                    end else begin
                        wr_err <= 1'b1;
                    end
                end
                ST_READ: begin
                    state <= ST_READ;
                    if (!empty) begin
                        head       <= head + 1'b1;
                        data_count <= data_count - 1'b1;
                        re         <= 1'b1;
                        rd_addr    <= head;
                        rd_ack     <= 1'b1;
                    end else begin
                        rd_err <= 1'b1;
                    end
                end
                ST_WR_ERR: begin
                    state  <= ST_WR_ERR;
                    wr_err <= 1'b1;
                end
                ST_RD_ERR: begin
                    state  <= ST_RD_ERR;
                    rd_err <= 1'b1;
                end
                ST_INIT:  state <= ST_INIT;
                ST_NO_OP: state <= ST_NO_OP;
                // Unused codes (and X) park in NO_OP with nothing else moving.
                default:  state <= ST_NO_OP;
            endcase
        end
    end

`ifdef FIFO_ERR_CNT_EN
    logic err_event;

    // Same conditions that raise wr_err / rd_err in the register block above.
    assign err_event = (next_state == ST_WRITE  && full)  ||
                       (next_state == ST_READ   && empty) ||
                       (next_state == ST_WR_ERR)          ||
                       (next_state == ST_RD_ERR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (err_event && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule : fifo_ptr_ctrl

// File: tb/tb_fifo_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_ptr_ctrl
// Directed bench for fifo_ptr_ctrl (ADDR_W = 3, depth 8). Inputs change on
// the falling edge; outputs are sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_ptr_ctrl;
    import fifo_pkg::*;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    next_state;
    logic [2:0]    state;
    logic [AW:0]   data_count;
    logic [AW-1:0] head, tail, wr_addr, rd_addr;
    logic          we, re, wr_ack, wr_err, rd_ack, rd_err, full, empty;
    logic [7:0]    err_cnt;

    int tests = 0;
    int fails = 0;

`ifdef FIFO_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    fifo_ptr_ctrl #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .next_state (next_state),
        .state      (state),
        .data_count (data_count),
        .head       (head),
        .tail       (tail),
        .we         (we),
        .wr_addr    (wr_addr),
        .re         (re),
        .rd_addr    (rd_addr),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .full       (full),
        .empty      (empty),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] ns);
        @(negedge clk);
        next_state = ns;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".state"}, state, ST_INIT);
        check({tag, ".count"}, data_count, 0);
        check({tag, ".head"},  head, 0);
        check({tag, ".tail"},  tail, 0);
        check({tag, ".waddr"}, wr_addr, 0);
        check({tag, ".raddr"}, rd_addr, 0);
        check({tag, ".strb"},  {we, re, wr_ack, wr_err, rd_ack, rd_err}, 0);
        check({tag, ".empty"}, empty, 1);
        check({tag, ".full"},  full, 0);
        check({tag, ".errcnt"}, err_cnt, 0);
    endtask

    initial begin
        reset      = 1'b1;
        next_state = ST_INIT;
        #2;
        check_reset_values("por");

        @(negedge clk);
        reset = 1'b0;

        // Fill from empty: wr_addr 0..7, tail wraps to 0.
        for (int i = 0; i < 8; i++) begin
            step(ST_WRITE);
            check("fill.we",    we, 1);
            check("fill.ack",   wr_ack, 1);
            check("fill.waddr", wr_addr, i);
            check("fill.count", data_count, i + 1);
            check("fill.tail",  tail, (i + 1) % 8);
        end
        check("fill.full",  full, 1);
        check("fill.empty", empty, 0);
        check("fill.head",  head, 0);

        // Overflow attempt.
        step(ST_WRITE);
        check("ovf.state", state, ST_WRITE);
        check("ovf.we",    we, 0);
        check("ovf.ack",   wr_ack, 0);
        check("ovf.err",   wr_err, 1);
        check("ovf.count", data_count, 8);
        check("ovf.tail",  tail, 0);
        check("ovf.errcnt", err_cnt, ERR_EN ? 1 : 0);

        // Drain: rd_addr 0..7.
        for (int i = 0; i < 8; i++) begin
            step(ST_READ);
            check("drain.re",    re, 1);
            check("drain.ack",   rd_ack, 1);
            check("drain.raddr", rd_addr, i);
            check("drain.count", data_count, 7 - i);
            check("drain.head",  head, (i + 1) % 8);
        end
        check("drain.empty", empty, 1);
        check("drain.full",  full, 0);

        // Underflow attempt.
        step(ST_READ);
        check("udf.state", state, ST_READ);
        check("udf.re",    re, 0);
        check("udf.ack",   rd_ack, 0);
        check("udf.err",   rd_err, 1);
        check("udf.count", data_count, 0);
        check("udf.errcnt", err_cnt, ERR_EN ? 2 : 0);

        // Wrap with interleave: 5 W, 3 R, 6 W from head=tail=0.
        for (int i = 0; i < 5; i++) step(ST_WRITE);
        for (int i = 0; i < 3; i++) step(ST_READ);
        check("ilv.count_mid", data_count, 2);
        for (int i = 0; i < 6; i++) step(ST_WRITE);
        check("ilv.tail",  tail, 3);
        check("ilv.head",  head, 3);
        check("ilv.count", data_count, 8);
        check("ilv.full",  full, 1);
        step(ST_READ);
        check("ilv.raddr", rd_addr, 3);
        check("ilv.re",    re, 1);
        check("ilv.count7", data_count, 7);
        check("ilv.head4", head, 4);

        // Bring count to 3, then reset mid-cycle while re is still high.
        for (int i = 0; i < 4; i++) step(ST_READ);
        check("pre_rst.count", data_count, 3);
        check("pre_rst.re",    re, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");

        // First edge after release loads next_state normally.
        @(negedge clk);
        reset      = 1'b0;
        next_state = ST_WRITE;
        @(posedge clk);
        #1;
        check("post_rst.state", state, ST_WRITE);
        check("post_rst.we",    we, 1);
        check("post_rst.waddr", wr_addr, 0);
        check("post_rst.count", data_count, 1);

        // Illegal codes at count = 4.
        for (int i = 0; i < 3; i++) step(ST_WRITE);
        step(ST_INIT);
        check("ill.pre_state", state, ST_INIT);
        check("ill.pre_count", data_count, 4);
        step(3'b111);
        check("ill111.state", state, ST_NO_OP);
        check("ill111.count", data_count, 4);
        check("ill111.head",  head, 0);
        check("ill111.tail",  tail, 4);
        check("ill111.waddr", wr_addr, 3);
        check("ill111.raddr", rd_addr, 0);
        check("ill111.strb",  {we, re, wr_ack, wr_err, rd_ack, rd_err}, 0);
        step(ST_INIT);
        step(3'b100);
        check("ill100.state", state, ST_NO_OP);
        check("ill100.count", data_count, 4);

        // Explicit error states.
        step(ST_WR_ERR);
        check("wrerr.state", state, ST_WR_ERR);
        check("wrerr.flags", {wr_err, rd_err, we}, 3'b100);
        check("wrerr.count", data_count, 4);
        step(ST_RD_ERR);
        check("rderr.state", state, ST_RD_ERR);
        check("rderr.flags", {wr_err, rd_err, re}, 3'b010);
        check("rderr.head",  head, 0);
        check("rderr.errcnt", err_cnt, ERR_EN ? 2 : 0);

        // 300 RD_ERR cycles: counter saturates at 255 (or stays 0).
        for (int i = 1; i <= 300; i++) begin
            step(ST_RD_ERR);
            if (i == 250) check("errcnt.mid", err_cnt, ERR_EN ? 252 : 0);
        end
        check("errcnt.sat", err_cnt, ERR_EN ? 255 : 0);
        check("errcnt.count", data_count, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fifo_ptr_ctrl
